// File: rtl/nios2_jtag_debug_action_sched.sv
// Sysclk-side sequencer for JTAG-initiated debug actions: synchronises update-DR
// toggles, issues one take-action pulse per event, tracks monitor handshake.
// Optional macro DBG_ACTION_STATS_EN enables the saturating completed-action counter.
module nios2_jtag_debug_action_sched #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        udr_toggle,
  input  logic [1:0]  ir_in,
  input  logic [1:0]  cmd,
  input  logic        monitor_ready,
  input  logic        monitor_error,
  output logic        take_action_ocimem,
  output logic        take_action_tracemem,
  output logic        take_action_break,
  output logic        take_action_tracectrl,
  output logic [1:0]  action_cmd,
  output logic        busy,
  output logic        done,
  output logic        err_sticky,
  output logic        overrun_sticky,
  output logic [15:0] action_count
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, DONE} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   sync_dly_p1;
  logic                   evt_p2;

  logic [1:0]       cur_ir, cur_cmd;
  logic [1:0]       pend_ir, pend_cmd;
  logic             pend_vld;
  logic [CNT_W-1:0] to_cnt;

  logic ld_pend, ld_evt, pend_set, pend_clr, ovr_set, err_set, cnt_inc, cnt_clr;

  // Synchroniser chain, edge detect and registered one-cycle event
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0     <= '0;
      sync_dly_p1 <= 1'b0;
      evt_p2      <= 1'b0;
    end else begin
      sync_p0     <= {sync_p0[SYNC_STAGES-2:0], udr_toggle};
      sync_dly_p1 <= sync_p0[SYNC_STAGES-1];
      evt_p2      <= sync_p0[SYNC_STAGES-1] ^ sync_dly_p1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_pend   = 1'b0;
    ld_evt    = 1'b0;
    pend_set  = 1'b0;
    pend_clr  = 1'b0;
    ovr_set   = 1'b0;
    err_set   = 1'b0;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;
    unique case (state)
      IDLE: begin
        if (pend_vld) begin
          state_nxt = ISSUE;
          ld_pend   = 1'b1;
          pend_clr  = 1'b1;
        end else if (evt_p2) begin
          state_nxt = ISSUE;
          ld_evt    = 1'b1;
        end
      end
      ISSUE: state_nxt = (cur_ir == 2'd0) ? WAIT_ACK : DONE;
      WAIT_ACK: begin
        if (monitor_ready) begin
          state_nxt = DONE;
          err_set   = monitor_error;
        end else if (to_cnt == TO_LAST) begin
          state_nxt = DONE;
          err_set   = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        cnt_clr   = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    // An event not consumed directly goes to the pending slot; when the slot
    // is being drained this same cycle it refills, otherwise a full slot drops it.
    if (evt_p2 && !ld_evt) begin
      if (pend_vld && !pend_clr) ovr_set  = 1'b1;
      else                       pend_set = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_vld       <= 1'b0;
      overrun_sticky <= 1'b0;
      err_sticky     <= 1'b0;
      to_cnt         <= '0;
    end else begin
      if (pend_set)      pend_vld <= 1'b1;
      else if (pend_clr) pend_vld <= 1'b0;
      if (ovr_set) overrun_sticky <= 1'b1;
      if (err_set) err_sticky     <= 1'b1;
      if (cnt_clr)      to_cnt <= '0;
      else if (cnt_inc) to_cnt <= to_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (ld_pend)     {cur_ir, cur_cmd} <= {pend_ir, pend_cmd};
    else if (ld_evt) {cur_ir, cur_cmd} <= {ir_in, cmd};
    if (pend_set)    {pend_ir, pend_cmd} <= {ir_in, cmd};
  end

  // Outputs are decoded from state so an asynchronous reset clears them at once
  assign take_action_ocimem    = (state == ISSUE) && (cur_ir == 2'd0);
  assign take_action_tracemem  = (state == ISSUE) && (cur_ir == 2'd1);
  assign take_action_break     = (state == ISSUE) && (cur_ir == 2'd2);
  assign take_action_tracectrl = (state == ISSUE) && (cur_ir == 2'd3);
  assign action_cmd            = (state == ISSUE) ? cur_cmd : 2'b00;
  assign busy                  = (state != IDLE);
  assign done                  = (state == DONE);

`ifdef DBG_ACTION_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] stat_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     stat_cnt <= 16'h0000;
    else if (done) stat_cnt <= sat_inc16(stat_cnt);
  end

  assign action_count = stat_cnt;
`else
  assign action_count = 16'h0000;
`endif

endmodule
